matrix_scan_scheduler: RTL and testbench

Sequences the dual 8x8 LED matrix scan and owns frame updates. The SPI shift registers continue to capture x/y frames while load is high. This block double-buffers those frames and commits a new frame only on a scan-frame boundary after load deasserts. It time-multiplexes columns and the two displays, inserts anti-ghosting blanking, and drives registered row/colx/coly pins.

---
 rtl/matrix_scan_scheduler.sv | 132 +++++++++++++
 tb/tb_matrix_scan_scheduler.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/matrix_scan_scheduler.sv
// matrix_scan_scheduler
// Scans a dual 8x8 LED matrix, one column of one display per slot, and
// double-buffers frames captured by the SPI shift registers. A new frame is
// committed only on a scan-frame boundary, and only after load has fallen.
//
// Ports:
//   clk           system clock
//   reset         synchronous, active-low
//   scan_en       1 = scan runs; 0 = counters hold, outputs blanked
//   load_async    SPI load pin (asynchronous, synchronised here)
//   shadow_x/y    72-bit SPI frames: [71:64] colsOn, column c row-off byte
//                 at [63-8c : 56-8c]
//   row           row-off drive for the current slot
//   colx/coly     one-hot (or 0) column drive for the x / y display
//   frame_start   one-cycle pulse on the first cycle of slot 0
//   commit_pulse  one-cycle pulse when the active frames were updated
//   pending       a captured frame is waiting for commit
module matrix_scan_scheduler #(
    parameter int TICK_DIV  = 16384,
    parameter int BLANK_CYC = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        scan_en,
    input  logic        load_async,
    input  logic [71:0] shadow_x,
    input  logic [71:0] shadow_y,
    output logic [7:0]  row,
    output logic [7:0]  colx,
    output logic [7:0]  coly,
    output logic        frame_start,
    output logic        commit_pulse,
    output logic        pending
);

    localparam int CYC_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(TICK_DIV - 1);

    logic [CYC_W-1:0] cyc;
    logic [3:0]       slot;
    logic             sync1;
    logic             load_s;
    logic             load_s_d;
    logic [71:0]      active_x;
    logic [71:0]      active_y;

    logic             load_fall;
    logic             boundary;
    logic             commit;
    logic             blank;
    logic [2:0]       col;
    logic             disp;
    logic [71:0]      frame;
    logic [7:0]       row_n;
    logic [7:0]       colx_n;
    logic [7:0]       coly_n;

    always_comb begin
        load_fall = load_s_d & ~load_s;
        boundary  = scan_en && (slot == 4'd15) && (cyc == CYC_LAST);
        // A commit taken while load is still high could tear a frame the
        // SPI side is still shifting in, so it is deferred a whole frame.
        commit    = boundary && pending && !load_s;
        blank     = !scan_en || (int'(cyc) < BLANK_CYC);
        col       = slot[3:1];
        disp      = slot[0];
        frame     = disp ? active_y : active_x;
        row_n     = frame[8*(7 - int'(col)) +: 8];
        colx_n    = '0;
        coly_n    = '0;
        if (!disp) begin
            colx_n[col] = frame[64 + int'(col)];
        end else begin
            coly_n[col] = frame[64 + int'(col)];
        end
        if (blank) begin
            row_n  = '0;
            colx_n = '0;
            coly_n = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            cyc          <= '0;
            slot         <= '0;
            sync1        <= 1'b0;
            load_s       <= 1'b0;
            load_s_d     <= 1'b0;
            pending      <= 1'b0;
            active_x     <= '0;
            active_y     <= '0;
            row          <= '0;
            colx         <= '0;
            coly         <= '0;
            frame_start  <= 1'b0;
            commit_pulse <= 1'b0;
        end else begin
            sync1    <= load_async;
            load_s   <= sync1;
            load_s_d <= load_s;

            if (scan_en) begin
                if (cyc == CYC_LAST) begin
                    cyc  <= '0;
                    slot <= slot + 4'd1;
                end else begin
                    cyc <= cyc + 1'b1;
                end
            end

            if (commit) begin
                active_x <= shadow_x;
                active_y <= shadow_y;
            end

            // A fresh capture landing on the commit cycle must survive it.
            if (load_fall) begin
                pending <= 1'b1;
            end else if (commit) begin
                pending <= 1'b0;
            end

            row          <= row_n;
            colx         <= colx_n;
            coly         <= coly_n;
            frame_start  <= boundary;
            commit_pulse <= commit;
        end
    end

endmodule

// File: tb/tb_matrix_scan_scheduler.sv
module tb_matrix_scan_scheduler;

    localparam int TD    = 8;
    localparam int BC    = 2;
    localparam int FRAME = 16 * TD;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        scan_en = 1'b1;
    logic        load_async = 1'b0;
    logic [71:0] shadow_x = '0;
    logic [71:0] shadow_y = '0;
    logic [7:0]  row;
    logic [7:0]  colx;
    logic [7:0]  coly;
    logic        frame_start;
    logic        commit_pulse;
    logic        pending;

    matrix_scan_scheduler #(.TICK_DIV(TD), .BLANK_CYC(BC)) dut (
        .clk          (clk),
        .reset        (reset),
        .scan_en      (scan_en),
        .load_async   (load_async),
        .shadow_x     (shadow_x),
        .shadow_y     (shadow_y),
        .row          (row),
        .colx         (colx),
        .coly         (coly),
        .frame_start  (frame_start),
        .commit_pulse (commit_pulse),
        .pending      (pending)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    endtask

    // ---------------- reference model ----------------
    // Scan position is a single frame-relative index; slot/column/display
    // are derived arithmetically. Load history holds the last three samples
    // of load_async (two-flop synchroniser plus the edge-detect flop).
    logic [26:0] exp_q[$];
    int          m_pos = 0;
    bit          m_pend = 0;
    logic [71:0] act_x = '0;
    logic [71:0] act_y = '0;
    bit          h1 = 0, h2 = 0, h3 = 0;

    function automatic logic [23:0] scan_pins(input int pos, input bit en,
                                              input logic [71:0] ax, input logic [71:0] ay);
        int          slot_i, c, is_y, cy;
        logic [71:0] f, sh;
        logic [7:0]  colbit;
        slot_i = pos / TD;
        cy     = pos % TD;
        c      = slot_i / 2;
        is_y   = slot_i % 2;
        if (!en || cy < BC) return '0;
        f      = (is_y != 0) ? ay : ax;
        sh     = f >> (56 - 8 * c);
        colbit = f[64 + c] ? 8'(1 << c) : 8'h00;
        return {sh[7:0], (is_y != 0) ? 8'h00 : colbit, (is_y != 0) ? colbit : 8'h00};
    endfunction

    initial forever begin
        bit          fall, ls, bnd, com;
        logic [23:0] pins;
        @(posedge clk);
        if (!reset) begin
            m_pos = 0; m_pend = 0; act_x = '0; act_y = '0;
            h1 = 0; h2 = 0; h3 = 0;
            exp_q.push_back('0);
        end else begin
            fall = h3 && !h2;
            ls   = h2;
            bnd  = scan_en && (m_pos == FRAME - 1);
            com  = bnd && m_pend && !ls;
            pins = scan_pins(m_pos, scan_en, act_x, act_y);
            if (com) begin
                act_x = shadow_x;
                act_y = shadow_y;
            end
            if (fall) m_pend = 1;
            else if (com) m_pend = 0;
            if (scan_en) m_pos = (m_pos + 1) % FRAME;
            h3 = h2; h2 = h1; h1 = load_async;
            exp_q.push_back({pins, bnd, com, m_pend});
        end
    end

    // ---------------- monitor ----------------
    int cycle_n  = 0;
    int fs_prev  = 0;
    int fs_last  = 0;
    int cp_count = 0;

    initial forever begin
        logic [26:0] e;
        @(negedge clk);
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("cycle_outputs", {37'd0, row, colx, coly, frame_start, commit_pulse, pending}, {37'd0, e});
            if (frame_start === 1'b1) begin
                fs_prev = fs_last;
                fs_last = cycle_n;
            end
            if (commit_pulse === 1'b1) cp_count++;
        end
        cycle_n++;
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_pos(input int p);
        int n = 0;
        while (m_pos != p && n < 400) begin
            step();
            n++;
        end
        if (m_pos != p) begin
            n_chk++;
            $display("FAIL wait_pos actual=%0d expected=%0d (timeout)", m_pos, p);
        end
    endtask

    task automatic pulse_load(input int hi);
        load_async = 1'b1;
        repeat (hi) step();
        load_async = 1'b0;
    endtask

    function automatic logic [71:0] rand72();
        logic [71:0] r;
        r[31:0]  = $urandom();
        r[63:32] = $urandom();
        r[71:64] = 8'($urandom());
        return r;
    endfunction

    initial begin
        int c0;
        reset = 1'b0;
        repeat (3) step();
        reset = 1'b1;

        // idle frame after reset: outputs dark, no commits
        repeat (130) step();
        check("idle_no_commit", 64'(cp_count), 64'd0);
        check("idle_pending", {63'd0, pending}, 64'd0);

        // single load pulse mid-frame
        wait_pos(30);
        shadow_x = {8'hFF, {8{8'h01}}};
        shadow_y = '0;
        pulse_load(3);
        repeat (3) step();
        check("pending_set", {63'd0, pending}, 64'd1);
        c0 = cp_count;
        wait_pos(1);
        check("first_commit", 64'(cp_count), 64'(c0 + 1));
        wait_pos(20);

        // load held high across a boundary defers the commit
        shadow_x = rand72();
        shadow_y = rand72();
        pulse_load(2);
        repeat (4) step();
        wait_pos(40);
        load_async = 1'b1;
        c0 = cp_count;
        wait_pos(10);
        check("deferred_no_commit", 64'(cp_count), 64'(c0));
        check("deferred_pending", {63'd0, pending}, 64'd1);
        load_async = 1'b0;
        wait_pos(64);
        wait_pos(3);
        check("deferred_commit", 64'(cp_count), 64'(c0 + 1));
        check("deferred_cleared", {63'd0, pending}, 64'd0);

        // two pulses in one frame: one commit, newest shadow wins
        wait_pos(8);
        c0 = cp_count;
        shadow_x = rand72();
        shadow_y = rand72();
        pulse_load(2);
        repeat (5) step();
        shadow_x = rand72();
        shadow_y = rand72();
        pulse_load(3);
        wait_pos(100);
        wait_pos(3);
        check("double_pulse_one_commit", 64'(cp_count), 64'(c0 + 1));

        // scan_en pause mid-slot 5 stretches the frame by the pause length
        wait_pos(5 * TD + 3);
        scan_en = 1'b0;
        repeat (20) step();
        scan_en = 1'b1;
        wait_pos(2);
        check("pause_period", 64'(fs_last - fs_prev), 64'(FRAME + 20));

        // reset on the boundary cycle with a frame pending
        wait_pos(20);
        shadow_x = rand72();
        shadow_y = rand72();
        pulse_load(2);
        repeat (4) step();
        check("pre_reset_pending", {63'd0, pending}, 64'd1);
        c0 = cp_count;
        wait_pos(FRAME - 1);
        reset = 1'b0;
        step();
        reset = 1'b1;
        check("reset_pending_clear", {63'd0, pending}, 64'd0);
        repeat (2) step();
        check("reset_no_commit", 64'(cp_count), 64'(c0));

        // randomized traffic
        for (int i = 0; i < 900; i++) begin
            step();
            if ($urandom_range(9) == 0) load_async = ~load_async;
            if (load_async) begin
                shadow_x = rand72();
                shadow_y = rand72();
            end
            scan_en = ($urandom_range(15) != 0);
            reset   = ($urandom_range(299) != 0);
        end
        reset = 1'b1;
        scan_en = 1'b1;
        load_async = 1'b0;
        repeat (300) step();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
